pll_rst_seq: RTL

- Controls the board PLL's reset input and consumes its lock output. This is the other end of the PLL reset/lock interface.
- Runs on the raw reference clock (24 MHz crystal), not the PLL output.
- Holds the PLL in reset, waits for lock with a timeout, and retries a bounded number of times.
- Requires lock to be stable before releasing system reset. Re-sequences if lock is lost; flags a sticky failure when retries run out.

---
 rtl/pll_rst_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset / lock sequencer running on the raw reference clock.
//
// Holds the PLL in reset, releases it, and waits (with a timeout) for lock.
// It retries a bounded number of times and parks the PLL in a sticky FAIL
// state once the retries run out. Lock must stay high for a qualification
// window before system reset is released. Losing lock in RUN starts a new
// sequence.
//
// Optional feature: define PLL_LOSS_CNT_EN to add the loss_cnt output. It is
// a saturating count of RUN->HOLD lock-loss events. Only rst_n clears it.
//
// Ports:
//   clk        in   reference clock (the same crystal net that feeds the PLL)
//   rst_n      in   asynchronous active-low reset
//   restart    in   pulse that starts a fresh sequence from any state
//   pll_lock   in   PLL lock, asynchronous to clk
//   pll_reset  out  active-high reset to the PLL
//   sys_rst_n  out  active-low system reset request (registered)
//   pll_locked out  synchronized lock (last sync stage)
//   pll_fail   out  sticky: retries exhausted
//   seq_state  out  FSM state (HOLD=0 WAIT=1 STABLE=2 RUN=3 FAIL=4)
//   retry_cnt  out  failed attempts in the current sequence
//   loss_cnt   out  [PLL_LOSS_CNT_EN only] lock-loss events, saturating at 255
module pll_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,     // must be 0..3 so retry_cnt cannot wrap
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       pll_locked,
  output logic       pll_fail,
  output logic [2:0] seq_state,
`ifdef PLL_LOSS_CNT_EN
  output logic [7:0] loss_cnt,
`endif
  output logic [1:0] retry_cnt
);

  // A single shared counter serves every state, so size it for the longest
  // count. It never runs past MAXC-1.
  localparam int MAX_RS = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAXC   = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             retry_q, retry_d;
  logic                   fail_q, fail_d;
  logic                   pll_reset_q, sys_rst_n_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;
`endif

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail_d  = fail_q;
`ifdef PLL_LOSS_CNT_EN
    loss_d  = loss_q;
`endif
    if (restart) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          // The lock is tested first, so a lock on the timeout cycle wins.
          if (lk) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = S_HOLD;
            end else begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A drop on the final qualification cycle still sends us back to WAIT.
          if (!lk) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lk) begin
            state_d = S_HOLD;
            cnt_d   = '0;
`ifdef PLL_LOSS_CNT_EN
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
          end
        end
        S_FAIL: ;
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The outputs are registered from the next state. That way they change on
  // the same edge that changes seq_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
`ifdef PLL_LOSS_CNT_EN
      loss_q      <= '0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      pll_reset_q <= (state_d == S_HOLD) || (state_d == S_FAIL);
      sys_rst_n_q <= (state_d == S_RUN);
`ifdef PLL_LOSS_CNT_EN
      loss_q      <= loss_d;
`endif
    end
  end

  assign pll_reset  = pll_reset_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign pll_locked = lk;
  assign pll_fail   = fail_q;
  assign seq_state  = state_q;
  assign retry_cnt  = retry_q;
`ifdef PLL_LOSS_CNT_EN
  assign loss_cnt   = loss_q;
`endif

endmodule
